fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC and
//   drives the instruction-memory address. Buffers fetched {pc, instr} pairs in a
//   small FIFO so decode can stall without losing fetches. Accepts a one-cycle
//   redirect (taken branch) that flushes the buffer and reloads the PC.
// PARAMETERS
//   XLEN         32         data/address width
//   RESET_PC     32'h0      PC value loaded on reset
//   QUEUE_DEPTH  2          FIFO entries; power of 2, >= 2
// PORTS
//   clk_i          in   1     clock; all state updates on rising edge
//   rst_i          in   1     synchronous, active-high reset
//   start_i        in   1     fetch enable; low = hold PC, no new fetches
//   redirect_i     in   1     branch taken: flush and reload PC this cycle
//   redirect_pc_i  in   XLEN  target PC for redirect_i
//   imem_addr_o    out  XLEN  instruction-memory address (= PC register)
//   imem_instr_i   in   XLEN  instruction at imem_addr_o, same cycle (comb read)
//   instr_valid_o  out  1     FIFO head valid toward IF/ID
//   instr_ready_i  in   1     IF/ID accepts head (low = hazard stall)
//   instr_o        out  XLEN  head instruction
//   pc_o           out  XLEN  PC of head instruction
// BEHAVIOUR
//   - Reset (rst_i=1 at edge): PC<=RESET_PC; count, rd/wr pointers <=0; FIFO
//     storage <=0. After reset: imem_addr_o=RESET_PC, instr_valid_o=0,
//     instr_o=0, pc_o=0. rst_i overrides redirect_i and all handshakes, including
//     mid-stall or mid-redirect.
//   - push = start_i & !redirect_i & (count < QUEUE_DEPTH). On push: store
//     {PC, imem_instr_i} at wr_ptr; PC <= PC+4 (mod 2^XLEN; 32'hFFFFFFFC wraps
//     to 0).
//   - instr_valid_o = (count != 0) & !redirect_i. pop = instr_valid_o &
//     instr_ready_i. Head = entry at rd_ptr, shown combinationally on instr_o and
//     pc_o.
//   - count: +1 push only, -1 pop only, unchanged on both or neither.
//     Pointers increment mod QUEUE_DEPTH.
//   - Full (count==QUEUE_DEPTH): no push even if pop the same cycle; PC holds.
//     Empty: valid low; ready ignored.
//   - redirect_i (highest priority after reset): count, pointers <=0;
//     PC <= {redirect_pc_i[XLEN-1:2], 2'b00}. No push and no pop that cycle.
//     The first target instruction is valid 2 cycles after the redirect edge
//     (fetch next cycle, visible the cycle after).
//   - start_i low: PC and push frozen; queued entries still drain.
//   - Latency: the PC fetched in cycle N is at the head in N+1 at the earliest.
//     Steady state with ready=1 is one instruction per cycle.
// STRUCTURE
//   - Shared package cpu_pkg: XLEN, RESET_PC default, INSTR_NOP=32'h00000013,
//     pc_instr_t struct {pc, instr}.
//   - Sub-module fetch_queue: synchronous FIFO (push/pop/count/full/empty/flush)
//     of pc_instr_t, depth QUEUE_DEPTH. fetch_unit adds the PC register, push
//     gating and redirect logic.
// TESTING
//   1. Reset, start_i=1, ready=1, imem returns addr-derived words -> valid rises
//      1 cycle after reset; pc_o = 0, 4, 8, ... one per cycle; no gaps.
//   2. ready=0 for 5 cycles from PC 8 -> queue fills at 2 entries; imem_addr_o
//      holds 0x10; on ready=1, heads 8, 0xC, 0x10 in order with no loss or
//      duplication.
//   3. redirect_i with redirect_pc_i=0x103 while queue full -> same cycle
//      valid=0; next cycle imem_addr_o=0x100 and valid=0; following cycle
//      pc_o=0x100.
//   4. Redirect with ready=1 and a valid head -> head not counted as popped;
//      no stale PC appears after the redirect.
//   5. start_i=0 with 2 queued entries -> both drain, then valid=0; PC frozen;
//      start_i=1 resumes at the frozen PC.
//   6. RESET_PC=32'hFFFFFFF8, run 3 fetches -> pc_o = FFFFFFF8, FFFFFFFC, 0;
//      assert rst_i mid-stall -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset defaults and the {pc, instr}
// record carried from fetch to decode.
package cpu_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } pc_instr_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} pairs between the PC and IF/ID.
// Flush discards all entries in one cycle; the head is read combinationally.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      flush_i,
   input  logic      push_i,
   input  logic      pop_i,
   input  pc_instr_t wdata_i,
   output pc_instr_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   pc_instr_t          mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (count == CNT_W'(DEPTH));
   assign empty_o = (count == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem[rd_ptr];

   // NOTE: storage is reset too, so the head reads as zero out of reset rather
   // than as X; a flush only moves the pointers because valid masks the stale head.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally and buffers
// {pc, instr} pairs so decode can stall; a redirect flushes and reloads the PC.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN        = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_instr_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o
);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_target;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   pc_instr_t       head;

   // Targets are word aligned; the low bits of the branch target are dropped.
   assign redirect_target = redirect_pc_i & ~XLEN'(3);

   assign push          = start_i & ~redirect_i & ~full;
   assign instr_valid_o = ~empty & ~redirect_i;
   assign pop           = instr_valid_o & instr_ready_i;

   assign imem_addr_o = pc;
   assign instr_o     = head.instr;
   assign pc_o        = head.pc;

   always_ff @(posedge clk_i) begin
      if (rst_i)           pc <= RESET_PC;
      else if (redirect_i) pc <= redirect_target;
      else if (push)       pc <= pc + XLEN'(4);
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ('{pc: pc, instr: imem_instr_i}),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference queue predicts every head
// presented to IF/ID; a second instance covers the PC wrap and mid-stall reset.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: RESET_PC = 0
   logic        rst = 1'b1, start = 1'b0, redirect = 1'b0, ready = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] addr_a, imem_a, instr_a, pc_a;
   logic        valid_a;

   // instance B: RESET_PC = 0xFFFFFFF8
   logic        rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b0, redirect_b = 1'b0;
   logic [31:0] redirect_pc_b = '0;
   logic [31:0] addr_b, imem_b, instr_b, pc_b;
   logic        valid_b;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
   endfunction

   assign imem_a = imem_word(addr_a);
   assign imem_b = imem_word(addr_b);

   fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_addr_o(addr_a), .imem_instr_i(imem_a),
      .instr_valid_o(valid_a), .instr_ready_i(ready), .instr_o(instr_a), .pc_o(pc_a)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .redirect_i(redirect_b),
      .redirect_pc_i(redirect_pc_b), .imem_addr_o(addr_b), .imem_instr_i(imem_b),
      .instr_valid_o(valid_b), .instr_ready_i(ready_b), .instr_o(instr_b), .pc_o(pc_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference state for instance A
   pc_instr_t   sb[$];
   logic [31:0] m_pc;

   // Called at a falling edge; returns at the next falling edge.
   task automatic step_a(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rdy);
      pc_instr_t exp;
      logic      m_valid, m_push;
      int        sz;
      start = st; redirect = rd; redirect_pc = rpc; ready = rdy;
      #1;
      sz      = sb.size();
      m_valid = (sz != 0) && !rd;
      m_push  = st && !rd && (sz < DEPTH);
      check("valid", 64'(valid_a), 64'(m_valid));
      check("imem_addr", 64'(addr_a), 64'(m_pc));
      if (m_valid) begin
         exp = rdy ? sb.pop_front() : sb[0];
         check("head_pc", 64'(pc_a), 64'(exp.pc));
         check("head_instr", 64'(instr_a), 64'(exp.instr));
      end
      if (rd) begin
         sb.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else if (m_push) begin
         sb.push_back('{pc: m_pc, instr: imem_word(m_pc)});
         m_pc = m_pc + 32'd4;
      end
      @(negedge clk);
   endtask

   // Reset through one rising edge with the other inputs left as they are.
   task automatic reset_a(input logic rd);
      rst = 1'b1; redirect = rd; redirect_pc = 32'h300;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_valid", 64'(valid_a), 64'(1'b0));
      check("rst_addr", 64'(addr_a), 64'(32'h0));
      check("rst_instr", 64'(instr_a), 64'(32'h0));
      check("rst_pc", 64'(pc_a), 64'(32'h0));
      sb.delete();
      m_pc = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      @(negedge clk);
      reset_a(1'b0);

      // steady stream up to head PC 8, then a 5-cycle hazard stall
      repeat (3) step_a(1'b1, 1'b0, '0, 1'b1);
      repeat (5) step_a(1'b1, 1'b0, '0, 1'b0);
      check("stall_addr_hold", 64'(addr_a), 64'(32'h10));
      repeat (6) step_a(1'b1, 1'b0, '0, 1'b1);

      // redirect while the queue is full; low address bits dropped
      repeat (2) step_a(1'b1, 1'b0, '0, 1'b0);
      step_a(1'b1, 1'b1, 32'h103, 1'b0);
      check("redirect_addr", 64'(addr_a), 64'(32'h100));
      repeat (4) step_a(1'b1, 1'b0, '0, 1'b1);

      // redirect while a valid head is being accepted
      step_a(1'b1, 1'b1, 32'h200, 1'b1);
      repeat (4) step_a(1'b1, 1'b0, '0, 1'b1);

      // start low with a full queue: drain, PC frozen, then resume
      repeat (3) step_a(1'b1, 1'b0, '0, 1'b0);
      repeat (4) step_a(1'b0, 1'b0, '0, 1'b1);
      repeat (4) step_a(1'b1, 1'b0, '0, 1'b1);

      // reset mid-stall, then reset during a redirect
      repeat (3) step_a(1'b1, 1'b0, '0, 1'b0);
      reset_a(1'b0);
      repeat (3) step_a(1'b1, 1'b0, '0, 1'b1);
      reset_a(1'b1);
      repeat (3) step_a(1'b1, 1'b0, '0, 1'b1);

      // instance B: PC wrap past the top of the address space
      start_b = 1'b1; ready_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      check("b_rst_addr", 64'(addr_b), 64'(32'hFFFF_FFF8));
      check("b_rst_valid", 64'(valid_b), 64'(1'b0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
         check("b_valid", 64'(valid_b), 64'(1'b1));
         check("b_pc", 64'(pc_b), 64'(exp_pc));
         check("b_instr", 64'(instr_b), 64'(imem_word(exp_pc)));
      end
      check("b_addr_wrap", 64'(addr_b), 64'(32'h4));

      // instance B: stall until full, then reset mid-stall
      ready_b = 1'b0;
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      check("b_rst2_addr", 64'(addr_b), 64'(32'hFFFF_FFF8));
      check("b_rst2_valid", 64'(valid_b), 64'(1'b0));
      check("b_rst2_instr", 64'(instr_b), 64'(32'h0));
      check("b_rst2_pc", 64'(pc_b), 64'(32'h0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
